// File: rtl/buffer_fill_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_fill_ctrl
//
// Write-side fill controller for the ping-pong SRAM buffer. Accepts a
// valid/ready word stream and turns each accepted word into a registered
// buffer write. It fills one bank while the consumer drains the other, and
// waits for the consumer to release a bank before refilling it.
//
// Optional feature: define GARUDA_FILL_PERF_CNT_EN to build the stall counter.
// Without it, stall_cycles_o is tied to zero.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   start_i         one-cycle tile fill request (honoured only in IDLE)
//   len_i           tile length in words, sampled with start_i
//   s_valid_i       stream word valid
//   s_data_i        stream word
//   s_ready_o       controller accepts a word this cycle
//   wr_en_o         buffer write enable (one cycle after the handshake)
//   wr_addr_o       buffer write address
//   wr_data_o       buffer write data
//   wr_bank_o       bank index for the write
//   bank_full_o     per-bank flag: the bank holds a complete tile
//   bank_release_i  per-bank pulse from the consumer that frees the bank
//   busy_o          FSM is not idle
//   done_o          one-cycle pulse when a tile is complete
//   err_o           one-cycle pulse when start_i carried an illegal length
//   stall_cycles_o  stall counter (zero unless GARUDA_FILL_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module buffer_fill_ctrl #(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_W:0]       len_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_bank_o,
    output logic [NUM_BANKS-1:0]  bank_full_o,
    input  logic [NUM_BANKS-1:0]  bank_release_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           stall_cycles_o
);

    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BANK,
        FILL,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q;
    logic [ADDR_W-1:0]    count_q;
    logic                 fill_bank_q;
    logic [NUM_BANKS-1:0] bank_full_q;
    logic [NUM_BANKS-1:0] bank_set;

    logic len_legal;
    logic start_ok;
    logic bank_free;
    logic hs;
    logic last_word;

    assign len_legal = (len_i != '0) && (len_i <= LEN_W'(DEPTH));
    assign start_ok  = (state_q == IDLE) && start_i && len_legal;
    assign bank_free = !bank_full_q[fill_bank_q];
    assign s_ready_o = (state_q == FILL);
    assign hs        = s_valid_i & s_ready_o;
    assign last_word = ({1'b0, count_q} == (len_q - LEN_W'(1)));
    assign busy_o    = (state_q != IDLE);
    assign bank_full_o = bank_full_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_ok)        state_d = WAIT_BANK;
            WAIT_BANK: if (bank_free)       state_d = FILL;
            FILL:      if (hs && last_word) state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // The bank completed in DONE is marked full; a release in the same cycle
    // for that bank loses against the set.
    always_comb begin
        bank_set = '0;
        if (state_q == DONE) begin
            bank_set[fill_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            fill_bank_q <= 1'b0;
            bank_full_q <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            wr_bank_o   <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= (bank_full_q & ~bank_release_i) | bank_set;
            err_o       <= (state_q == IDLE) && start_i && !len_legal;
            done_o      <= (state_q == DONE);
            wr_en_o     <= hs;

            if (start_ok) begin
                len_q <= len_i;
            end

            if ((state_q == WAIT_BANK) && bank_free) begin
                count_q <= '0;
            end else if (hs) begin
                count_q <= count_q + ADDR_W'(1);
            end

            if (hs) begin
                wr_addr_o <= count_q;
                wr_data_o <= s_data_i;
                wr_bank_o <= fill_bank_q;
            end

            if (state_q == DONE) begin
                fill_bank_q <= ~fill_bank_q;
            end
        end
    end

`ifdef GARUDA_FILL_PERF_CNT_EN
    logic [31:0] stall_q;
    logic        stall_now;

    assign stall_now      = (state_q == WAIT_BANK) || ((state_q == FILL) && !s_valid_i);
    assign stall_cycles_o = stall_q;

    // Saturating stall counter, restarted by each accepted legal start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for buffer_fill_ctrl. Stimulus pushes expected writes, done pulses
// and error pulses into queues; a monitor on the falling edge pops and
// compares whenever the DUT presents one of those outputs.
// -----------------------------------------------------------------------------
module tb_buffer_fill_ctrl;

    localparam int DEPTH = 4096;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_bank_o;
    logic [1:0]    bank_full_o;
    logic [1:0]    bank_release_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [31:0]   stall_cycles_o;

    buffer_fill_ctrl #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .NUM_BANKS  (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .len_i          (len_i),
        .s_valid_i      (s_valid_i),
        .s_data_i       (s_data_i),
        .s_ready_o      (s_ready_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_bank_o      (wr_bank_o),
        .bank_full_o    (bank_full_o),
        .bank_release_i (bank_release_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        bank;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  err_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Monitor: compares presented writes / pulses against the queues.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wr_en_o) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", wr_en_o, 1'b0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_bank", wr_bank_o, e.bank);
                    check("wr_addr", wr_addr_o, e.addr);
                    check("wr_data", wr_data_o, e.data);
                    check("wr_latency", cyc, e.cyc);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) check("unexpected_done", done_o, 1'b0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            if (err_o) begin
                if (err_q.size() == 0) check("unexpected_err", err_o, 1'b0);
                else check("err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    // One tile fill. blk_rel != 0 means both banks are full on entry and the
    // bench releases blk_rel after observing the stall. abort >= 0 stops the
    // stream before word 'abort' and returns with the tile incomplete.
    task automatic fill(input int len, input bit gap, input logic [31:0] base,
                        input logic [1:0] blk_rel, input logic [1:0] rel_done,
                        input int abort, input logic [1:0] exp_full, input logic exp_bank);
        int n;
        start_i = 1'b1;
        len_i   = LW'(len);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        if (blk_rel != 2'b00) begin
            for (int k = 0; k < 8; k++) begin
                check("blocked_busy", busy_o, 1'b1);
                check("blocked_ready", s_ready_o, 1'b0);
                tick();
            end
            bank_release_i = blk_rel;
            tick();
            bank_release_i = '0;
            check("release_clears", bank_full_o, 2'b11 & ~blk_rel);
        end
        n = 0;
        while (s_ready_o !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("ready_latency", n, 1);
        for (int i = 0; i < len; i++) begin
            if (i == abort) begin
                s_valid_i = 1'b0;
                return;
            end
            if (gap && i > 0) begin
                // Idle beat; an illegal start here must be ignored silently.
                s_valid_i = 1'b0;
                start_i   = 1'b1;
                len_i     = '0;
                tick();
                start_i   = 1'b0;
            end
            s_valid_i = 1'b1;
            s_data_i  = base + 32'(i);
            check("ready_in_fill", s_ready_o, 1'b1);
            wr_q.push_back('{exp_bank, i, base + 32'(i), cyc + 1});
            if (i == len - 1) done_q.push_back(cyc + 2);
            tick();
        end
        s_valid_i      = 1'b0;
        bank_release_i = rel_done;
        check("ready_in_done", s_ready_o, 1'b0);
        tick();
        bank_release_i = '0;
        check("busy_after_tile", busy_o, 1'b0);
        check("bank_full_after_tile", bank_full_o, exp_full);
    endtask

    task automatic check_reset_values();
        check("rst_wr_en", wr_en_o, 1'b0);
        check("rst_wr_addr", wr_addr_o, '0);
        check("rst_wr_data", wr_data_o, '0);
        check("rst_wr_bank", wr_bank_o, 1'b0);
        check("rst_s_ready", s_ready_o, 1'b0);
        check("rst_bank_full", bank_full_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_stall", stall_cycles_o, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        start_i        = 1'b0;
        len_i          = '0;
        s_valid_i      = 1'b0;
        s_data_i       = '0;
        bank_release_i = '0;
        repeat (2) tick();
        check_reset_values();
        rst_ni = 1'b1;
        tick();

        // Tile 1: 4 words back-to-back into bank 0.
        fill(4, 1'b0, 32'hA0, 2'b00, 2'b00, -1, 2'b01, 1'b0);

        // Tile 2: 8 words with an idle beat between words, into bank 1.
        fill(8, 1'b1, 32'hB000_0000, 2'b00, 2'b00, -1, 2'b11, 1'b1);
`ifdef GARUDA_FILL_PERF_CNT_EN
        // One WAIT_BANK cycle plus the seven idle beats driven above.
        check("stall_cycles", stall_cycles_o, 32'd8);
`else
        check("stall_cycles", stall_cycles_o, 32'd0);
`endif

        // Tile 3: both banks full, release bank 0, then a full-depth fill.
        fill(DEPTH, 1'b0, 32'hC000_0000, 2'b01, 2'b00, -1, 2'b11, 1'b0);

        // Illegal lengths: zero and DEPTH+1.
        start_i = 1'b1;
        len_i   = '0;
        err_q.push_back(cyc + 1);
        tick();
        start_i = 1'b0;
        check("err_len0_busy", busy_o, 1'b0);
        tick();
        start_i = 1'b1;
        len_i   = LW'(DEPTH + 1);
        err_q.push_back(cyc + 1);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        check("err_lenmax_busy", busy_o, 1'b0);
        tick();
        check("err_idle_busy", busy_o, 1'b0);

        // Release both banks, then release an already-clear bank.
        bank_release_i = 2'b11;
        tick();
        bank_release_i = 2'b00;
        check("release_both", bank_full_o, 2'b00);
        bank_release_i = 2'b01;
        tick();
        bank_release_i = 2'b00;
        check("release_clear_bank", bank_full_o, 2'b00);

        // Tile 4 aborted by reset after 3 of 6 words (fill pointer is bank 1).
        fill(6, 1'b0, 32'hD0, 2'b00, 2'b00, 3, 2'b00, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values();
        tick();
        rst_ni = 1'b1;
        tick();

        // Tile 5 goes to bank 0; release of bank 0 during DONE loses to the set.
        fill(2, 1'b0, 32'hE0, 2'b00, 2'b01, -1, 2'b01, 1'b0);
        repeat (2) tick();

        check("wr_queue_drained", wr_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
